sap1_controller: RTL and testbench
==================================

Name: sap1_controller

Overview:
- Controller-sequencer for the SAP-1 datapath. Sits directly upstream of the memory address register (MAR) and produces its enable and source-select strobes, plus every other control line (PC, RAM, IR, A, B, ALU, OUT).
- A one-hot six-state ring counter (T1..T6) steps through fetch and execute.
- Control lines are decoded from the current T-state and the IR opcode nibble.

Parameters:
- OP_LDA, 4'h0, opcode for load A from memory
- OP_ADD, 4'h1, opcode for A <= A + mem
- OP_SUB, 4'h2, opcode for A <= A - mem
- OP_OUT, 4'he, opcode for OUT <= A
- OP_HLT, 4'hf, opcode for halt

Ports:
- clk  in  1  main clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- run  in  1  sequencer enable; low freezes the T-state
- opcode  in  4  IR upper nibble; valid from T4 onward
- Emar  out  1  MAR synchronous enable
- LmPC  out  1  MAR source = PC
- LmIRa  out  1  MAR source = IR lower nibble
- pc_inc  out  1  PC increment strobe
- ram_rd  out  1  RAM read onto bus
- ir_load  out  1  IR load from bus
- a_load  out  1  accumulator load from bus
- a_out  out  1  accumulator drives bus
- b_load  out  1  B register load from bus
- alu_sub  out  1  ALU subtract select (0 = add)
- alu_out  out  1  ALU result drives bus
- out_load  out  1  output register load
- t_state  out  6  one-hot current T-state (bit0 = T1)
- halted  out  1  high while in HALT

Behaviour:
- State register: one-hot T1..T6 plus a HALT state. It is the only sequential element.
- Reset:
  - rst=1 at posedge sets state to T1.
  - While rst=1, all control outputs are forced to 0; t_state=6'b000001; halted=0.
  - Reset mid-instruction or while in HALT aborts and returns to T1; no partial strobes follow.
- Advance: on posedge with rst=0 and run=1, T1->T2->...->T6->T1.
- run=0: state holds and all control outputs are forced to 0. Resuming continues from the held T-state.
- Control outputs are combinational from state and opcode. Each is asserted for exactly one clock per T-state. Zero latency from state to strobe; targets capture on the closing edge.
- Fetch (all opcodes):
  - T1: Emar=1, LmPC=1. MAR <= PC at end of T1.
  - T2: pc_inc=1.
  - T3: ram_rd=1, ir_load=1. IR is captured at end of T3.
- Execute, LDA:
  - T4: Emar=1, LmIRa=1.
  - T5: ram_rd=1, a_load=1.
  - T6: none.
- Execute, ADD:
  - T4: Emar=1, LmIRa=1.
  - T5: ram_rd=1, b_load=1.
  - T6: alu_out=1, a_load=1, alu_sub=0.
- Execute, SUB: same as ADD, with alu_sub=1 in both T5 and T6.
- Execute, OUT:
  - T4: a_out=1, out_load=1.
  - T5, T6: none.
- Execute, HLT:
  - T4: no strobes. The next posedge (run=1) enters HALT.
  - HALT: all controls 0, halted=1, t_state=0. Ignores run and opcode. Exits only via rst.
- Undefined opcodes execute as NOP: T4..T6 produce no strobes, then the sequence returns to T1.
- Invariants:
  - LmPC and LmIRa are never both 1.
  - Neither LmPC nor LmIRa is asserted without Emar.
  - At most one bus driver (ram_rd, a_out, alu_out) is asserted at a time.
- opcode is ignored in T1..T3. A change of opcode within T4..T6 is reflected combinationally; the IR holds it stable in normal operation.

Test Plan:
- Reset: hold rst=1 for 2 cycles with run=1 -> all strobes 0, t_state=000001; first cycle after release shows Emar=1, LmPC=1.
- LDA fetch/execute: run=1, opcode=4'h0 -> per-cycle strobe sequence {Emar+LmPC}, {pc_inc}, {ram_rd+ir_load}, {Emar+LmIRa}, {ram_rd+a_load}, {} -> back to t_state=000001.
- SUB: opcode=4'h2 -> T5 shows ram_rd, b_load, alu_sub; T6 shows alu_out, a_load, alu_sub; no other strobes.
- run gating: drop run during T3 for 3 cycles -> all strobes 0 and t_state stays 000100; raise run -> T3 strobes reappear, then T4.
- HLT: opcode=4'hf -> after T4, halted=1 and t_state=0, constant for 20 cycles with run toggling; rst=1 -> T1, halted=0.
- Undefined opcode 4'h7, plus rst asserted during T5 of an ADD -> NOP sequence with no strobes in T4..T6; mid-ADD reset returns to T1 with no b_load or a_load emitted after the reset edge.

Source files
------------

// File: rtl/sap1_ctrl_if.sv
// ============================================================================
// Module      : sap1_ctrl_if
// Description : SAP-1 controller <-> datapath control bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sap1_ctrl_if;
    logic       run;
    logic [3:0] opcode;
    logic       Emar;
    logic       LmPC;
    logic       LmIRa;
    logic       pc_inc;
    logic       ram_rd;
    logic       ir_load;
    logic       a_load;
    logic       a_out;
    logic       b_load;
    logic       alu_sub;
    logic       alu_out;
    logic       out_load;
    logic [5:0] t_state;
    logic       halted;

    // Controller side
    modport master (
        input  run, opcode,
        output Emar, LmPC, LmIRa, pc_inc, ram_rd, ir_load, a_load, a_out,
               b_load, alu_sub, alu_out, out_load, t_state, halted
    );

    // Datapath side
    modport slave (
        output run, opcode,
        input  Emar, LmPC, LmIRa, pc_inc, ram_rd, ir_load, a_load, a_out,
               b_load, alu_sub, alu_out, out_load, t_state, halted
    );
endinterface

`default_nettype wire

// File: rtl/sap1_controller.sv
// ============================================================================
// Module      : sap1_controller
// Description : SAP-1 ring-counter sequencer and control-line decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sap1_controller #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'he,
    parameter logic [3:0] OP_HLT = 4'hf
) (
    input  wire logic      clk,
    input  wire logic      rst,
    sap1_ctrl_if.master    bus
);

    // Low six bits map directly onto the one-hot t_state output.
    typedef enum logic [6:0] {
        S_T1   = 7'b000_0001,
        S_T2   = 7'b000_0010,
        S_T3   = 7'b000_0100,
        S_T4   = 7'b000_1000,
        S_T5   = 7'b001_0000,
        S_T6   = 7'b010_0000,
        S_HALT = 7'b100_0000
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_en;
    logic w_Emar, w_LmPC, w_LmIRa, w_pc_inc, w_ram_rd, w_ir_load;
    logic w_a_load, w_a_out, w_b_load, w_alu_sub, w_alu_out, w_out_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_T1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_T1;
        case (r_state)
            S_T1:    w_next = bus.run ? S_T2 : S_T1;
            S_T2:    w_next = bus.run ? S_T3 : S_T2;
            S_T3:    w_next = bus.run ? S_T4 : S_T3;
            S_T4:    w_next = !bus.run ? S_T4 :
                              (bus.opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:    w_next = bus.run ? S_T6 : S_T5;
            S_T6:    w_next = bus.run ? S_T1 : S_T6;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_T1;
        endcase
    end

    assign w_en = !rst && bus.run;

    always_comb begin
        w_Emar     = 1'b0;
        w_LmPC     = 1'b0;
        w_LmIRa    = 1'b0;
        w_pc_inc   = 1'b0;
        w_ram_rd   = 1'b0;
        w_ir_load  = 1'b0;
        w_a_load   = 1'b0;
        w_a_out    = 1'b0;
        w_b_load   = 1'b0;
        w_alu_sub  = 1'b0;
        w_alu_out  = 1'b0;
        w_out_load = 1'b0;
        if (w_en) begin
            case (r_state)
                S_T1: begin
                    w_Emar = 1'b1;
                    w_LmPC = 1'b1;
                end
                S_T2: w_pc_inc = 1'b1;
                S_T3: begin
                    w_ram_rd  = 1'b1;
                    w_ir_load = 1'b1;
                end
                S_T4: begin
                    if (bus.opcode == OP_LDA || bus.opcode == OP_ADD ||
                        bus.opcode == OP_SUB) begin
                        w_Emar  = 1'b1;
                        w_LmIRa = 1'b1;
                    end else if (bus.opcode == OP_OUT) begin
                        w_a_out    = 1'b1;
                        w_out_load = 1'b1;
                    end
                end
                S_T5: begin
                    if (bus.opcode == OP_LDA) begin
                        w_ram_rd = 1'b1;
                        w_a_load = 1'b1;
                    end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        w_ram_rd  = 1'b1;
                        w_b_load  = 1'b1;
                        w_alu_sub = (bus.opcode == OP_SUB);
                    end
                end
                S_T6: begin
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        w_alu_out = 1'b1;
                        w_a_load  = 1'b1;
                        w_alu_sub = (bus.opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Emar     = w_Emar;
    assign bus.LmPC     = w_LmPC;
    assign bus.LmIRa    = w_LmIRa;
    assign bus.pc_inc   = w_pc_inc;
    assign bus.ram_rd   = w_ram_rd;
    assign bus.ir_load  = w_ir_load;
    assign bus.a_load   = w_a_load;
    assign bus.a_out    = w_a_out;
    assign bus.b_load   = w_b_load;
    assign bus.alu_sub  = w_alu_sub;
    assign bus.alu_out  = w_alu_out;
    assign bus.out_load = w_out_load;
    assign bus.t_state  = rst ? 6'b000001 : r_state[5:0];
    assign bus.halted   = !rst && (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_sap1_controller.sv
// ============================================================================
// Module      : tb_sap1_controller
// Description : Directed + randomized self-checking bench for sap1_controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sap1_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sap1_ctrl_if bus ();

    sap1_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [11:0] EMAR  = 12'h800, LMPC  = 12'h400, LMIRA = 12'h200,
                            PCINC = 12'h100, RAMRD = 12'h080, IRLD  = 12'h040,
                            ALD   = 12'h020, AOUT  = 12'h010, BLD   = 12'h008,
                            ASUB  = 12'h004, AUOUT = 12'h002, OUTLD = 12'h001;

    int errors = 0;
    int checks = 0;

    // Reference model: instruction step 1..6 and a halt flag
    int m_step = 1;
    bit m_halt = 1'b0;

    function automatic logic [11:0] exp_ctrl(int step, bit h, bit r, bit rn, logic [3:0] op);
        if (r || !rn || h) return 12'h000;
        case (step)
            1: return EMAR | LMPC;
            2: return PCINC;
            3: return RAMRD | IRLD;
            4: case (op)
                   4'h0, 4'h1, 4'h2: return EMAR | LMIRA;
                   4'he:             return AOUT | OUTLD;
                   default:          return 12'h000;
               endcase
            5: case (op)
                   4'h0:    return RAMRD | ALD;
                   4'h1:    return RAMRD | BLD;
                   4'h2:    return RAMRD | BLD | ASUB;
                   default: return 12'h000;
               endcase
            6: case (op)
                   4'h1:    return AUOUT | ALD;
                   4'h2:    return AUOUT | ALD | ASUB;
                   default: return 12'h000;
               endcase
            default: return 12'h000;
        endcase
    endfunction

    task automatic do_cycle(input bit r, input bit rn, input logic [3:0] op, input string tag);
        logic [11:0] obs_c, exp_c;
        logic [5:0]  exp_t;
        bit          exp_h;
        @(negedge clk);
        rst        = r;
        bus.run    = rn;
        bus.opcode = op;
        #1;
        obs_c = {bus.Emar, bus.LmPC, bus.LmIRa, bus.pc_inc, bus.ram_rd, bus.ir_load,
                 bus.a_load, bus.a_out, bus.b_load, bus.alu_sub, bus.alu_out, bus.out_load};
        exp_c = exp_ctrl(m_step, m_halt, r, rn, op);
        exp_t = r ? 6'b000001 : (m_halt ? 6'b000000 : 6'(1 << (m_step - 1)));
        exp_h = !r && m_halt;
        checks++;
        assert (obs_c === exp_c) else begin
            errors++;
            $error("FAIL %s ctrl: observed=%03h expected=%03h", tag, obs_c, exp_c);
        end
        checks++;
        assert (bus.t_state === exp_t) else begin
            errors++;
            $error("FAIL %s t_state: observed=%06b expected=%06b", tag, bus.t_state, exp_t);
        end
        checks++;
        assert (bus.halted === exp_h) else begin
            errors++;
            $error("FAIL %s halted: observed=%0b expected=%0b", tag, bus.halted, exp_h);
        end
        @(posedge clk);
        if (r) begin
            m_step = 1;
            m_halt = 1'b0;
        end else if (!m_halt && rn) begin
            if (m_step == 4 && op == 4'hf) m_halt = 1'b1;
            else m_step = (m_step == 6) ? 1 : m_step + 1;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, op, tag);
    endtask

    initial begin
        logic [3:0] op;
        logic [3:0] pool [5];
        pool[0] = 4'h0; pool[1] = 4'h1; pool[2] = 4'h2; pool[3] = 4'he; pool[4] = 4'hf;
        rst = 1'b1;
        bus.run = 1'b1;
        bus.opcode = 4'h0;

        do_cycle(1'b1, 1'b1, 4'h0, "reset");
        do_cycle(1'b1, 1'b1, 4'h0, "reset");
        run_instr(4'h0, "lda");
        run_instr(4'h1, "add");
        run_instr(4'h2, "sub");
        run_instr(4'he, "out");

        // Stall in T3 for three cycles, then finish the instruction
        do_cycle(1'b0, 1'b1, 4'h1, "gate");
        do_cycle(1'b0, 1'b1, 4'h1, "gate");
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 4'h1, "gate_hold");
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 4'h1, "gate_resume");

        run_instr(4'h7, "nop");

        // Reset lands in T5 of an ADD
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 4'h1, "add_abort");
        do_cycle(1'b1, 1'b1, 4'h1, "add_abort_rst");
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 4'h1, "after_abort");
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 4'h0, "after_abort");

        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 4'hf, "hlt");
        for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'(i % 2), 4'($urandom), "halted");
        do_cycle(1'b1, 1'b1, 4'hf, "halt_rst");
        do_cycle(1'b0, 1'b1, 4'h0, "post_halt");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) op = 4'($urandom);
            else op = pool[$urandom_range(0, 4)];
            do_cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 6) != 0), op, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
